// File: rtl/flash_read_seq.sv
// SPI NOR read sequencer: sends the read header through the SPI byte engine, then streams data bytes out on a valid/ready port.
// Define FLASH_SEQ_FAST_READ_EN to use FAST READ (0x0B) with one dummy byte; otherwise plain READ (0x03).
module flash_read_seq #(
  parameter int LEN_W = 16
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [23:0]      req_addr_i,
  input  logic [LEN_W-1:0] req_len_i,
  output logic [7:0]       data_o,
  output logic             data_valid_o,
  input  logic             data_ready_i,
  output logic             done_o,
  output logic             spi_en_o,
  output logic [7:0]       spi_wr_data_o,
  output logic             spi_wr_valid_o,
  input  logic             spi_wr_ready_i,
  input  logic [7:0]       spi_rd_data_i,
  input  logic             spi_rd_valid_i,
  output logic             spi_rd_ready_o
);

`ifdef FLASH_SEQ_FAST_READ_EN
  localparam logic [7:0] OPCODE  = 8'h0B;
  localparam logic [2:0] HDR_LEN = 3'd5;
`else
  localparam logic [7:0] OPCODE  = 8'h03;
  localparam logic [2:0] HDR_LEN = 3'd4;
`endif
  localparam logic [LEN_W-1:0] LEN_ONE = LEN_W'(1);

  typedef enum logic [2:0] {S_IDLE, S_HDR, S_READ, S_CLOSE, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [23:0]      addr_q, addr_d;
  logic [LEN_W-1:0] rem_q, rem_d;
  logic [2:0]       hdr_idx_q, hdr_idx_d;
  logic [2:0]       hdr_rx_q, hdr_rx_d;
  logic [7:0]       data_q, data_d;
  logic             data_valid_q, data_valid_d;
  logic             spi_en_q, spi_en_d;
  logic             done_q, done_d;

  logic             hdr_done;
  logic             data_take;
  logic [7:0]       hdr_byte;

  assign hdr_done  = (hdr_rx_q == HDR_LEN);
  assign data_take = (state_q == S_READ) && spi_rd_valid_i && hdr_done;

  always_comb begin
    hdr_byte = 8'h00;
    case (hdr_idx_q)
      3'd0:    hdr_byte = OPCODE;
      3'd1:    hdr_byte = addr_q[23:16];
      3'd2:    hdr_byte = addr_q[15:8];
      3'd3:    hdr_byte = addr_q[7:0];
`ifdef FLASH_SEQ_FAST_READ_EN
      3'd4:    hdr_byte = 8'h00;
`endif
      default: hdr_byte = 8'h00;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    rem_d        = rem_q;
    hdr_idx_d    = hdr_idx_q;
    hdr_rx_d     = hdr_rx_q;
    data_d       = data_q;
    data_valid_d = data_valid_q;
    spi_en_d     = spi_en_q;
    done_d       = 1'b0;

    // Bytes clocked back while the header is still going out are counted and dropped.
    if (spi_rd_valid_i && (hdr_rx_q < HDR_LEN)) hdr_rx_d = hdr_rx_q + 3'd1;
    if (data_valid_q && data_ready_i) data_valid_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (req_valid_i) begin
          addr_d    = req_addr_i;
          rem_d     = req_len_i;
          hdr_idx_d = 3'd0;
          hdr_rx_d  = 3'd0;
          if (req_len_i == '0) begin
            state_d = S_DONE;
          end else begin
            spi_en_d = 1'b1;
            state_d  = S_HDR;
          end
        end
      end
      S_HDR: begin
        if (spi_wr_ready_i) begin
          hdr_idx_d = hdr_idx_q + 3'd1;
          if (hdr_idx_q == HDR_LEN - 3'd1) state_d = S_READ;
        end
      end
      S_READ: begin
        if (data_take) begin
          data_d       = spi_rd_data_i;
          data_valid_d = 1'b1;
          rem_d        = rem_q - LEN_ONE;
          // Dropping enable on the last byte's pulse lets the engine raise CSn at its next wait step.
          if (rem_q == LEN_ONE) begin
            spi_en_d = 1'b0;
            state_d  = S_CLOSE;
          end
        end
      end
      S_CLOSE: begin
        if (!data_valid_q && spi_wr_ready_i) state_d = S_DONE;
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      rem_q        <= '0;
      hdr_idx_q    <= '0;
      hdr_rx_q     <= '0;
      data_q       <= '0;
      data_valid_q <= 1'b0;
      spi_en_q     <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      rem_q        <= rem_d;
      hdr_idx_q    <= hdr_idx_d;
      hdr_rx_q     <= hdr_rx_d;
      data_q       <= data_d;
      data_valid_q <= data_valid_d;
      spi_en_q     <= spi_en_d;
      done_q       <= done_d;
    end
  end

  assign req_ready_o    = (state_q == S_IDLE);
  assign data_o         = data_q;
  assign data_valid_o   = data_valid_q;
  assign done_o         = done_q;
  assign spi_en_o       = spi_en_q;
  assign spi_wr_valid_o = (state_q == S_HDR);
  assign spi_wr_data_o  = (state_q == S_HDR) ? hdr_byte : 8'h00;
  assign spi_rd_ready_o = (state_q == S_READ) && hdr_done && (rem_q != '0) && !data_valid_q;

endmodule

// File: doc/flash_read_seq.md
# flash_read_seq

SPI NOR flash read sequencer that sits directly upstream of the SPI byte engine. It accepts a read request (24-bit address, byte count) and drives the engine's enable, write-byte and read-continue handshakes to issue the flash read command, address and optional dummy byte. It then streams the returned data bytes to the application through a valid/ready port. It discards the bytes clocked back during the header, and closes the bitstream so that chip select rises exactly after the last requested byte.

## Interface
- LEN_W, 16: width of the byte-count field; maximum request is 2^LEN_W-1 bytes.
- clk_i  in  1  clock.
- rstn_i  in  1  reset, asynchronous, active-low.
- req_valid_i  in  1  read request present.
- req_ready_o  out  1  request accepted when both high; high only in IDLE.
- req_addr_i  in  24  flash start address.
- req_len_i  in  LEN_W  number of data bytes to read.
- data_o  out  8  read data byte.
- data_valid_o  out  1  data_o valid; held until data_ready_i.
- data_ready_i  in  1  application accepts data_o.
- done_o  out  1  one-cycle pulse when the request has fully completed.
- spi_en_o  out  1  to engine en_i.
- spi_wr_data_o  out  8  to engine wr_data_i.
- spi_wr_valid_o  out  1  to engine wr_valid_i.
- spi_wr_ready_i  in  1  from engine wr_ready_o.
- spi_rd_data_i  in  8  from engine rd_data_o.
- spi_rd_valid_i  in  1  from engine rd_valid_o; single-cycle pulse per completed byte.
- spi_rd_ready_o  out  1  to engine rd_ready_i.

## Operation
- The header length is H = 4: opcode, addr[23:16], addr[15:8], addr[7:0]. It is 5 with the dummy byte (see Configuration).
- **IDLE**
  - req_ready_o=1.
  - On req_valid_i: latch address and length into remaining counter `rem`, clear hdr_idx and hdr_rx.
    - If req_len_i=0: go to DONE; no SPI activity.
    - Otherwise: set spi_en_o=1 and go to HDR.
- **HDR**
  - spi_wr_valid_o=1.
  - spi_wr_data_o is the header byte selected by hdr_idx.
  - On spi_wr_valid_o & spi_wr_ready_i: hdr_idx+1.
  - After byte H-1 is accepted, go to READ.
- **Header byte counting (any state)**
  - Every spi_rd_valid_i pulse while hdr_rx<H increments hdr_rx.
  - The byte is discarded.
- **READ**
  - spi_rd_ready_o = (hdr_rx==H) & (rem!=0) & ~data_valid_o (combinational).
  - Only one byte is ever in flight, so the output register is always empty when it completes.
  - On spi_rd_valid_i with hdr_rx==H:
    - data_o<=spi_rd_data_i, data_valid_o<=1, rem-1.
    - If rem==1: spi_en_o<=0 and go to CLOSE.
- **CLOSE**
  - Wait until data_valid_o==0 and spi_wr_ready_i==1. The engine is then back in idle and CSn is high.
  - Then go to DONE.
- **DONE**: done_o=1 for one cycle, then IDLE.
- **Output register**: data_valid_o clears on data_ready_i when no new byte loads in the same cycle.

## Timing
- **Reset values**:
  - All outputs are 0 except req_ready_o, which follows state IDLE (reset state) and is 1.
  - spi_wr_data_o=0x00.
  - Counters are cleared.
- **Reset mid-operation**: all state is cleared immediately, and the engine is reset by the same rstn_i.
- **Request acceptance**: spi_en_o and spi_wr_valid_o rise on the clock edge after the req handshake.
- **Engine continue decision**: spi_rd_ready_o and spi_en_o are updated in the same clk_i edge as the triggering spi_rd_valid_i pulse. This makes them stable before the engine's next gated wait-state evaluation, so no extra byte is clocked after the last one.
- **Read throughput**: one byte per SPI byte time plus one engine wait step.
- **Stalls**: data_ready_i low stalls SCK between bytes. CSn stays low during the stall.
- **Latency, request to first data_valid_o**: (H+1) SPI byte times plus engine overhead.
- **Count width**: rem is LEN_W bits and never wraps; a new request is refused until DONE.
- **Address**: passed through unchanged; flash-side wrap at top of array is the device's behaviour.
- **req_valid_i outside IDLE**: ignored.

## Configuration
- FLASH_SEQ_FAST_READ_EN defined:
  - Opcode is 0x0B (FAST READ).
  - One 0x00 dummy byte is appended after the address, so H=5 and five header rd_valid pulses are discarded.
- Not defined:
  - Opcode is 0x03 (READ).
  - H=4, and the hdr_idx mux has no dummy entry.

## Test plan
- Request addr 0x012345, len 3, flash model returns 0xA0,0xA1,0xA2 → MOSI 0x03,0x01,0x23,0x45. Then three data_valid_o beats 0xA0,0xA1,0xA2, CSn high after exactly 7 SCK bytes (56 SCK rising edges), then a single done_o pulse.
- len 0 → req accepted, done_o pulses 2 cycles later, CSn never falls, no data_valid_o.
- len 4 with data_ready_i low for 50 cycles after first beat → data_o held at byte 0, SCK idle, CSn low. After release, the remaining 3 bytes arrive in order with no byte lost or duplicated.
- FLASH_SEQ_FAST_READ_EN, addr 0xFFFFFE, len 2 → MOSI 0x0B,0xFF,0xFF,0xFE,0x00, then 2 data beats; 7 SCK bytes total.
- Back-to-back requests (len 1, len 1) with req_valid_i held → CSn high for at least one gated cycle between transactions, two done_o pulses.
- rstn_i asserted during the second address byte → all outputs return to reset values immediately. CSn is high, and a following len 1 request completes normally.
